// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller slice: FSM encodings,
// counter width and default timing constants for the pedestrian input path.
package semaforo_pkg;

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] DEB_CYCLES_DEF = 8'd3;
    localparam logic [CNT_W-1:0] COOLDOWN_DEF   = 8'd2;

    typedef enum logic [1:0] {
        D_LOW  = 2'd0,
        D_RISE = 2'd1,
        D_HIGH = 2'd2,
        D_FALL = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PEND = 2'd1,
        R_COOL = 2'd2
    } req_state_t;

endpackage

// File: rtl/bt_debounce.sv
// Two-flop synchroniser plus debounce FSM for the pedestrian push-button.
// Emits a single-cycle press when a high level survives DEB_CYCLES samples.
module bt_debounce
    import semaforo_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_EFF = (DEB_CYCLES == '0) ? CNT_W'(1) : DEB_CYCLES;

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse s1/s2 into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= D_LOW;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            D_LOW: begin
                if (s2) begin
                    if (DEB_EFF == CNT_W'(1)) begin
                        state_nxt = D_HIGH;
                        cnt_nxt   = '0;
                        press     = 1'b1;
                    end else begin
                        state_nxt = D_RISE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            D_RISE: begin
                if (!s2) begin
                    state_nxt = D_LOW;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DEB_EFF) begin
                    state_nxt = D_HIGH;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            D_HIGH: begin
                if (!s2) begin
                    if (DEB_EFF == CNT_W'(1)) begin
                        state_nxt = D_LOW;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = D_FALL;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            D_FALL: begin
                // A release is silent; a bounce back high just resumes the held state.
                if (s2) begin
                    state_nxt = D_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt_inc >= DEB_EFF) begin
                    state_nxt = D_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = D_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pedestrian_request.sv
// Pedestrian request conditioner: turns debounced presses into a bt pulse and
// a held req until ack, then blocks new requests for a cooldown window.
module pedestrian_request #(
    parameter logic [semaforo_pkg::CNT_W-1:0] DEB_CYCLES = semaforo_pkg::DEB_CYCLES_DEF,
    parameter logic [semaforo_pkg::CNT_W-1:0] COOLDOWN   = semaforo_pkg::COOLDOWN_DEF,
    parameter int                             CNT_W      = semaforo_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bt_raw,
    input  logic             ack,
    output logic             bt,
    output logic             req,
    output logic             cooling,
    output logic [CNT_W-1:0] drop_cnt
);

    import semaforo_pkg::req_state_t, semaforo_pkg::R_IDLE,
           semaforo_pkg::R_PEND, semaforo_pkg::R_COOL;

    localparam int CW = semaforo_pkg::CNT_W;

    logic             press;
    req_state_t       state;
    req_state_t       state_nxt;
    logic [CW-1:0]    cool_cnt;
    logic [CW-1:0]    cool_nxt;
    logic             bt_nxt;
    logic [CNT_W-1:0] drop_nxt;
    logic [CNT_W-1:0] drop_sat;

    bt_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (bt_raw),
        .press(press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= R_IDLE;
            cool_cnt <= '0;
            bt       <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cool_cnt <= cool_nxt;
            bt       <= bt_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    assign drop_sat = (drop_cnt == '1) ? drop_cnt : drop_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cool_nxt  = cool_cnt;
        bt_nxt    = 1'b0;
        drop_nxt  = drop_cnt;
        case (state)
            R_IDLE: begin
                if (press) begin
                    state_nxt = R_PEND;
                    bt_nxt    = 1'b1;
                end
            end
            R_PEND: begin
                // A press coinciding with ack is still a press while pending: dropped.
                if (press) drop_nxt = drop_sat;
                if (ack) begin
                    if (COOLDOWN == '0) begin
                        state_nxt = R_IDLE;
                    end else begin
                        state_nxt = R_COOL;
                        cool_nxt  = COOLDOWN;
                    end
                end
            end
            R_COOL: begin
                if (press) drop_nxt = drop_sat;
                if (cool_cnt <= CW'(1)) begin
                    state_nxt = R_IDLE;
                    cool_nxt  = '0;
                end else begin
                    cool_nxt = cool_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = R_IDLE;
                cool_nxt  = '0;
            end
        endcase
    end

    assign req     = (state == R_PEND);
    assign cooling = (state == R_COOL);

endmodule

// File: tb/tb_pedestrian_request.sv
// Directed bench for pedestrian_request: a per-cycle vector table for the
// main scenarios plus hand-written reset and saturation sequences.
module tb_pedestrian_request;

    typedef struct {
        logic       raw;
        logic       ack;
        logic       bt;
        logic       req;
        logic       cool;
        logic [7:0] drop;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       bt_raw;
    logic       ack;
    logic       bt;
    logic       req;
    logic       cooling;
    logic [7:0] drop_cnt;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    pedestrian_request dut (
        .clk     (clk),
        .rst     (rst),
        .bt_raw  (bt_raw),
        .ack     (ack),
        .bt      (bt),
        .req     (req),
        .cooling (cooling),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic r, input logic a, input logic b,
                       input logic q, input logic c, input logic [7:0] d);
        for (int i = 0; i < n; i++) vecs.push_back('{r, a, b, q, c, d});
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " bt"},       {31'd0, bt},      32'd0);
        check({tag, " req"},      {31'd0, req},     32'd0);
        check({tag, " cooling"},  {31'd0, cooling}, 32'd0);
        check({tag, " drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // raw ack | bt req cool drop ; entry numbers are edges after reset release
        add(4, 1, 0, 0, 0, 0, 0);   // 1-4   clean press being debounced
        add(1, 1, 0, 1, 1, 0, 0);   // 5     pulse after edge DEB+2
        add(5, 1, 0, 0, 1, 0, 0);   // 6-10  held: no repeat
        add(6, 0, 0, 0, 1, 0, 0);   // 11-16 release
        add(4, 1, 0, 0, 1, 0, 0);   // 17-20 second press while pending
        add(2, 1, 0, 0, 1, 0, 1);   // 21-22 dropped
        add(4, 0, 0, 0, 1, 0, 1);   // 23-26
        add(3, 1, 0, 0, 1, 0, 1);   // 27-29 press building up
        add(1, 1, 1, 0, 0, 1, 1);   // 30    ack -> cooldown
        add(1, 1, 1, 0, 0, 1, 2);   // 31    press in window dropped; ack ignored
        add(1, 1, 0, 0, 0, 0, 2);   // 32    window over after 2 cycles
        add(6, 0, 0, 0, 0, 0, 2);   // 33-38
        add(1, 1, 0, 0, 0, 0, 2);   // 39    bounce 1
        add(1, 0, 1, 0, 0, 0, 2);   // 40    bounce 0, ack in idle ignored
        add(2, 1, 0, 0, 0, 0, 2);   // 41-42 bounce 1,1
        add(1, 0, 0, 0, 0, 0, 2);   // 43    bounce 0
        add(4, 1, 0, 0, 0, 0, 2);   // 44-47 final run 1,1,1 then hold
        add(1, 1, 0, 1, 1, 0, 2);   // 48    single accepted pulse
        add(2, 1, 0, 0, 1, 0, 2);   // 49-50
        add(3, 0, 0, 0, 1, 0, 2);   // 51-53
        add(4, 1, 0, 0, 1, 0, 2);   // 54-57
        add(1, 1, 1, 0, 0, 1, 3);   // 58    press and ack together: ack wins
        add(1, 1, 0, 0, 0, 1, 3);   // 59
        add(3, 1, 0, 0, 0, 0, 3);   // 60-62 still held: no new request
        add(3, 0, 0, 0, 0, 0, 3);   // 63-65
        add(4, 1, 0, 0, 0, 0, 3);   // 66-69
        add(1, 1, 0, 1, 1, 0, 3);   // 70    fresh press after window
        add(1, 1, 0, 0, 1, 0, 3);   // 71

        // Power-on reset with the button held down.
        rst    = 1'b0;
        bt_raw = 1'b1;
        ack    = 1'b0;
        #1;
        check_idle_zero("por async");
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle_zero($sformatf("por cycle%0d", i));
        end
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bt_raw = vecs[i].raw;
            ack    = vecs[i].ack;
            step();
            check($sformatf("vec%0d bt", i + 1),       {31'd0, bt},       {31'd0, vecs[i].bt});
            check($sformatf("vec%0d req", i + 1),      {31'd0, req},      {31'd0, vecs[i].req});
            check($sformatf("vec%0d cooling", i + 1),  {31'd0, cooling},  {31'd0, vecs[i].cool});
            check($sformatf("vec%0d drop_cnt", i + 1), {24'd0, drop_cnt}, {24'd0, vecs[i].drop});
        end
        ack = 1'b0;

        // Reset while pending and debounced high: everything clears at once.
        rst = 1'b0;
        #1;
        check_idle_zero("midreset async");
        for (int i = 0; i < 2; i++) begin
            step();
            check_idle_zero($sformatf("midreset cycle%0d", i));
        end
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("post-reset edge%0d bt", i), {31'd0, bt}, 32'd0);
        end
        step();
        check("post-reset edge5 bt", {31'd0, bt}, 32'd1);
        check("post-reset edge5 req", {31'd0, req}, 32'd1);
        step();
        check("post-reset edge6 bt", {31'd0, bt}, 32'd0);

        // Saturation: repeated clean presses while pending.
        for (int i = 0; i < 100; i++) begin
            bt_raw = 1'b0;
            repeat (4) step();
            bt_raw = 1'b1;
            repeat (4) step();
        end
        bt_raw = 1'b0;
        repeat (4) step();
        check("drop_cnt after 100", {24'd0, drop_cnt}, 32'd100);
        for (int i = 0; i < 160; i++) begin
            bt_raw = 1'b0;
            repeat (4) step();
            bt_raw = 1'b1;
            repeat (4) step();
        end
        bt_raw = 1'b0;
        repeat (4) step();
        check("drop_cnt saturated", {24'd0, drop_cnt}, 32'd255);
        check("req after saturation", {31'd0, req}, 32'd1);
        check("bt after saturation", {31'd0, bt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pedestrian_request.md
Name: pedestrian_request

Overview:
- Upstream conditioner for the traffic-light controller's pedestrian button input `bt`.
- Takes the raw, asynchronous, bouncy push-button and synchronises and debounces it.
- Converts each accepted press into one single-cycle `bt` pulse plus a held `req` level that stays high until the controller acknowledges service.
- After service, a cooldown window blocks new requests so a pedestrian cannot starve the green phase.

Parameters:
- DEB_CYCLES, 8'd3: consecutive synchronised samples required to accept a level change; range 1..255; 0 is treated as 1.
- COOLDOWN, 8'd2: cycles after `ack` during which accepted presses are discarded; range 0..255.
- CNT_W, 8: counter width, matching the controller's 8-bit phase durations.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- bt_raw  in  1  raw button, asynchronous to clk, may bounce.
- ack  in  1  from controller; high while the pedestrian phase is being served (A red).
- bt  out  1  one-cycle pulse per granted request; drives controller `bt`.
- req  out  1  request pending; high from grant until `ack` is seen.
- cooling  out  1  high during the cooldown window.
- drop_cnt  out  CNT_W  saturating count of accepted presses discarded while pending or cooling.

Behaviour:
- Reset, asynchronous, rst=0: sync flops, debounce state/counter, req FSM, cooldown counter, bt, req, cooling and drop_cnt all go to 0. Release is sampled at the next clk edge.
- Synchroniser: 2 flops, s1 <= bt_raw and s2 <= s1. Only s2 feeds the logic.
- Debouncer FSM states are D_LOW, D_RISE, D_HIGH and D_FALL.
  - D_LOW: s2=1 -> D_RISE, cnt=1.
  - D_RISE: s2=1 -> cnt+1; when cnt reaches DEB_CYCLES -> D_HIGH and emit `press` for 1 cycle. s2=0 -> D_LOW, cnt=0.
  - D_HIGH: s2=0 -> D_FALL, cnt=1.
  - D_FALL: s2=0 -> cnt+1; at DEB_CYCLES -> D_LOW, with no event. s2=1 -> D_HIGH.
  - At most one `press` per physical press. Holding the button produces no repeats.
- Latency: bt_raw goes stable high before edge 1; s2 is high after edge 2; `press` is registered into bt/req at edge DEB_CYCLES+2. With defaults, bt is high in the cycle after edge 5.
- Request FSM states are R_IDLE, R_PEND and R_COOL.
  - R_IDLE: press -> R_PEND; bt=1 for exactly that one cycle; req=1.
  - R_PEND: ack=1 -> R_COOL; req=0 next cycle; cooldown counter loads COOLDOWN. If COOLDOWN=0, go directly to R_IDLE.
  - R_PEND, press arrives: discarded, drop_cnt+1.
  - R_COOL: cooling=1; counter decrements each cycle; reaching 0 -> R_IDLE.
  - R_COOL, press arrives: discarded, drop_cnt+1.
- ack in R_IDLE or R_COOL is ignored.
- Simultaneous press and ack in R_PEND: ack wins; press counted as dropped.
- drop_cnt saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- bt is never high for two consecutive cycles.
- bt never asserts while req was already 1 in the previous cycle.
- Reset mid-debounce or mid-pending: all state is lost; no bt pulse is emitted after release until a fresh, fully debounced press.
- Glitch on bt_raw shorter than one clk: it may or may not reach s2; either way it is filtered unless it persists DEB_CYCLES samples.

Decomposition:
- Shared package (`semaforo_pkg`) holds:
  - debounce state encodings D_* (2 bits) and request state encodings R_* (2 bits);
  - default constants DEB_CYCLES_DEF=8'd3 and COOLDOWN_DEF=8'd2;
  - CNT_W=8, shared with the controller's VERDE/AMARELO/VERMELHO durations.
- Sub-module `bt_debounce`:
  - contains the synchroniser plus the debouncer FSM;
  - ports: clk, rst, raw, press;
  - parameter: DEB_CYCLES.
- `pedestrian_request` instantiates `bt_debounce` and holds the request FSM, the cooldown counter and drop_cnt.

Test Plan:
- Reset: rst=0 with bt_raw=1 for 3 cycles, then release -> bt=req=cooling=0 and drop_cnt=0 throughout reset; first bt pulse only after DEB_CYCLES+2 edges past release.
- Clean press, defaults: bt_raw high from before edge 1 for 10 cycles -> bt=1 only in the cycle after edge 5; req=1 from edge 5 on; no further pulse while held.
- Bounce: bt_raw pattern 1,0,1,1,0,1,1,1 (one value per cycle) -> only the final 3-high run is accepted; exactly one bt pulse; drop_cnt=0.
- Press while pending: second clean press with req=1 -> no bt; drop_cnt=1; req stays 1.
- Ack and cooldown: ack=1 for one cycle -> req=0 and cooling=1 for 2 cycles; a press accepted inside the window gives drop_cnt+1 and no bt; a press after the window -> bt pulse, req=1.
- Simultaneous press and ack: align `press` with ack=1 in R_PEND -> next cycle req=0, cooling=1, drop_cnt+1, bt=0.
